// File: rtl/tri_batch_tracker.sv
// tri_batch_tracker: batch controller and per-ray closest/any-hit reducer.
// Walks (triangle, ray) pairs with the triangle descending and the ray as
// the inner loop, issues them to an external intersection pipeline under a
// credit limit, and reduces returned results into a per-ray best hit.
//
// Request handshake: o_req_valid/o_req_tri/o_req_ray form a valid/ready
// channel. An item transfers on a cycle where o_req_valid & i_req_ready are
// both high. Once o_req_valid is high it stays high with a stable payload
// until that transfer happens; a hit arriving for the same ray meanwhile does
// not withdraw it. The result channel has no ready: every i_res_valid cycle
// in ISSUE or DRAIN is consumed.
module tri_batch_tracker #(
  parameter int NRAYS     = 4,
  parameter int W         = 32,
  parameter int IDXW      = 32,
  parameter int RIDW      = 2,
  parameter int MAX_OUTST = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [IDXW-1:0]       i_tri_cnt,
  input  logic                  i_mode,
  output logic                  o_busy,
  output logic                  o_req_valid,
  output logic [IDXW-1:0]       o_req_tri,
  output logic [RIDW-1:0]       o_req_ray,
  input  logic                  i_req_ready,
  input  logic                  i_res_valid,
  input  logic [RIDW-1:0]       i_res_ray,
  input  logic [IDXW-1:0]       i_res_tri,
  input  logic                  i_res_hit,
  input  logic [W-1:0]          i_res_t,
  output logic                  o_done,
  output logic [NRAYS-1:0]      o_hit,
  output logic [NRAYS*W-1:0]    o_t,
  output logic [NRAYS*IDXW-1:0] o_tri_idx,
  output logic [1:0]            o_dbg_state
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [W-1:0] FIP_MAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic                 mode_q;
  logic                 held_q;
  logic [IDXW-1:0]      cur_tri;
  logic [RIDW-1:0]      cur_ray;
  logic [CW-1:0]        outst_q;
  logic [NRAYS-1:0]     hit_q;
  logic signed [W-1:0]  t_q   [NRAYS];
  logic [IDXW-1:0]      idx_q [NRAYS];

  logic cur_hit;
  logic skip;
  logic credit_ok;
  logic req_valid;
  logic accept;
  logic advance;
  logic last_pair;
  logic res_take;
  logic dec;

  // Issue/skip/credit decisions for the current cursor pair and result intake.
  always_comb begin
    cur_hit = 1'b0;
    for (int r = 0; r < NRAYS; r++) begin
      if (cur_ray == RIDW'(r)) cur_hit = hit_q[r];
    end
    skip      = mode_q && cur_hit;
    credit_ok = outst_q < CW'(MAX_OUTST);
    // A held request ignores skip: it was already presented and must complete.
    req_valid = (state_q == S_ISSUE) && (held_q || (!skip && credit_ok));
    accept    = req_valid && i_req_ready;
    advance   = accept || ((state_q == S_ISSUE) && !held_q && skip);
    last_pair = (cur_tri == '0) && (cur_ray == RIDW'(NRAYS - 1));
    res_take  = i_res_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    // Never decrement below zero on a stray result.
    dec       = res_take && (outst_q != '0);
  end

  // Batch FSM, cursor, credit counter and per-ray reduction.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      held_q  <= 1'b0;
      cur_tri <= '0;
      cur_ray <= '0;
      outst_q <= '0;
      hit_q   <= '0;
      for (int r = 0; r < NRAYS; r++) begin
        t_q[r]   <= '0;
        idx_q[r] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            mode_q  <= i_mode;
            cur_tri <= i_tri_cnt - IDXW'(1);
            cur_ray <= '0;
            outst_q <= '0;
            held_q  <= 1'b0;
            hit_q   <= '0;
            for (int r = 0; r < NRAYS; r++) begin
              t_q[r]   <= FIP_MAX;
              idx_q[r] <= '0;
            end
            state_q <= (i_tri_cnt == '0) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          held_q <= req_valid && !i_req_ready;
          if (advance) begin
            if (last_pair) begin
              state_q <= S_DRAIN;
            end else if (cur_ray == RIDW'(NRAYS - 1)) begin
              cur_ray <= '0;
              cur_tri <= cur_tri - IDXW'(1);
            end else begin
              cur_ray <= cur_ray + RIDW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (outst_q == '0) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (accept && !dec) begin
        outst_q <= outst_q + CW'(1);
      end else if (!accept && dec) begin
        outst_q <= outst_q - CW'(1);
      end

      // Out-of-range ray ids match no entry and only release a credit.
      if (res_take && i_res_hit) begin
        for (int r = 0; r < NRAYS; r++) begin
          if (i_res_ray == RIDW'(r)) begin
            if (mode_q ? !hit_q[r] : ($signed(i_res_t) < t_q[r])) begin
              hit_q[r] <= 1'b1;
              t_q[r]   <= i_res_t;
              idx_q[r] <= i_res_tri;
            end
          end
        end
      end
    end
  end

  // Output decode and per-ray packing.
  always_comb begin
    o_t       = '0;
    o_tri_idx = '0;
    for (int r = 0; r < NRAYS; r++) begin
      o_t[W*r +: W]             = t_q[r];
      o_tri_idx[IDXW*r +: IDXW] = idx_q[r];
    end
    o_hit       = hit_q;
    o_busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    o_done      = (state_q == S_DONE);
    o_req_valid = req_valid;
    o_req_tri   = cur_tri;
    o_req_ray   = cur_ray;
    o_dbg_state = state_q;
  end

endmodule

// File: tb/tb_tri_batch_tracker.sv
// Bench for tri_batch_tracker: a main instance (MAX_OUTST=64) and a credit
// instance (MAX_OUTST=2). Expected request pairs are queued when a batch is
// started and popped on each accepted request; expected per-ray results come
// from a small reduction model over the bench's hit tables.
module tb_tri_batch_tracker;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int IW = 32;
  localparam int RW = 2;
  localparam int PW = IW + RW;

  logic clk;
  logic rstn;

  // main instance signals
  logic            i_start, i_mode, i_req_ready, i_res_valid, i_res_hit;
  logic [IW-1:0]   i_tri_cnt, i_res_tri;
  logic [RW-1:0]   i_res_ray;
  logic [W-1:0]    i_res_t;
  logic            o_busy, o_req_valid, o_done;
  logic [IW-1:0]   o_req_tri;
  logic [RW-1:0]   o_req_ray;
  logic [NR-1:0]   o_hit;
  logic [NR*W-1:0] o_t;
  logic [NR*IW-1:0] o_tri_idx;
  logic [1:0]      o_dbg_state;

  // credit instance signals
  logic            c_start, c_mode, c_ready, c_res_valid, c_res_hit;
  logic [IW-1:0]   c_cnt, c_res_tri;
  logic [RW-1:0]   c_res_ray;
  logic [W-1:0]    c_res_t;
  logic            c_busy, c_valid, c_done;
  logic [IW-1:0]   c_tri;
  logic [RW-1:0]   c_ray;
  logic [NR-1:0]   c_hit;
  logic [NR*W-1:0] c_t;
  logic [NR*IW-1:0] c_idx;
  logic [1:0]      c_dbg;

  tri_batch_tracker #(.NRAYS(NR), .W(W), .IDXW(IW), .RIDW(RW), .MAX_OUTST(64)) u_dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(i_start), .i_tri_cnt(i_tri_cnt), .i_mode(i_mode),
    .o_busy(o_busy), .o_req_valid(o_req_valid), .o_req_tri(o_req_tri), .o_req_ray(o_req_ray),
    .i_req_ready(i_req_ready), .i_res_valid(i_res_valid), .i_res_ray(i_res_ray),
    .i_res_tri(i_res_tri), .i_res_hit(i_res_hit), .i_res_t(i_res_t), .o_done(o_done),
    .o_hit(o_hit), .o_t(o_t), .o_tri_idx(o_tri_idx), .o_dbg_state(o_dbg_state)
  );

  tri_batch_tracker #(.NRAYS(NR), .W(W), .IDXW(IW), .RIDW(RW), .MAX_OUTST(2)) u_crd (
    .i_clk(clk), .i_rstn(rstn), .i_start(c_start), .i_tri_cnt(c_cnt), .i_mode(c_mode),
    .o_busy(c_busy), .o_req_valid(c_valid), .o_req_tri(c_tri), .o_req_ray(c_ray),
    .i_req_ready(c_ready), .i_res_valid(c_res_valid), .i_res_ray(c_res_ray),
    .i_res_tri(c_res_tri), .i_res_hit(c_res_hit), .i_res_t(c_res_t), .o_done(c_done),
    .o_hit(c_hit), .o_t(c_t), .o_tri_idx(c_idx), .o_dbg_state(c_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] pend_q[$];
  logic [PW-1:0] c_exp_q[$];
  logic [PW-1:0] c_pend_q[$];
  bit            hit_tab [8][NR];
  logic [W-1:0]  t_tab   [8][NR];
  bit            exp_hit [NR];
  logic [W-1:0]  exp_t   [NR];
  logic [IW-1:0] exp_idx [NR];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_acc, n_res;
  bit  hold_res, done_seen, done_busy;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic clear_tab();
    for (int t = 0; t < 8; t++)
      for (int r = 0; r < NR; r++) begin
        hit_tab[t][r] = 1'b0;
        t_tab[t][r]   = '0;
      end
  endtask

  // Reference walk: issue order, any-hit skipping, and per-ray reduction.
  task automatic build_expected(input int cnt, input bit mode);
    exp_q.delete();
    for (int r = 0; r < NR; r++) begin
      exp_hit[r] = 1'b0;
      exp_t[r]   = 32'h7FFF_FFFF;
      exp_idx[r] = '0;
    end
    for (int t = cnt - 1; t >= 0; t--)
      for (int r = 0; r < NR; r++) begin
        if (!(mode && exp_hit[r])) begin
          exp_q.push_back({IW'(t), RW'(r)});
          if (hit_tab[t][r] && (mode || ($signed(t_tab[t][r]) < $signed(exp_t[r])))) begin
            exp_hit[r] = 1'b1;
            exp_t[r]   = t_tab[t][r];
            exp_idx[r] = IW'(t);
          end
        end
      end
  endtask

  task automatic check_final();
    for (int r = 0; r < NR; r++) begin
      check_eq($sformatf("hit%0d", r), o_hit[r], exp_hit[r]);
      check_eq($sformatf("t%0d", r), o_t[W*r +: W], exp_t[r]);
      check_eq($sformatf("idx%0d", r), o_tri_idx[IW*r +: IW], exp_idx[r]);
    end
  endtask

  task automatic start_batch(input int cnt, input bit mode);
    i_start   = 1'b1;
    i_tri_cnt = IW'(cnt);
    i_mode    = mode;
  endtask

  // One bench cycle on the main instance: observe at negedge, then drive
  // the pipeline model's result (one cycle after accept) after the posedge.
  task automatic step();
    logic [PW-1:0] e, p;
    @(negedge clk);
    if (o_done) begin
      done_seen = 1'b1;
      done_busy = o_busy;
    end
    if (o_req_valid && i_req_ready) begin
      if (exp_q.size() == 0) check_eq("req_extra", {o_req_tri, o_req_ray}, '1);
      else begin
        e = exp_q.pop_front();
        check_eq("req_pair", {o_req_tri, o_req_ray}, e);
      end
      pend_q.push_back({o_req_tri, o_req_ray});
      n_acc++;
    end
    @(posedge clk);
    #1;
    i_start = 1'b0;
    if (!hold_res && pend_q.size() > 0) begin
      p = pend_q.pop_front();
      i_res_valid = 1'b1;
      i_res_tri   = p[PW-1:RW];
      i_res_ray   = p[RW-1:0];
      i_res_hit   = hit_tab[int'(p[PW-1:RW])][int'(p[RW-1:0])];
      i_res_t     = t_tab[int'(p[PW-1:RW])][int'(p[RW-1:0])];
      n_res++;
    end else begin
      i_res_valid = 1'b0;
    end
  endtask

  task automatic run_batch(input int cnt, input bit mode, input bit poke);
    int cyc;
    pend_q.delete();
    n_acc = 0; n_res = 0; hold_res = 1'b0;
    build_expected(cnt, mode);
    start_batch(cnt, mode);
    cyc = 0; done_seen = 1'b0; done_busy = 1'b1;
    while (!done_seen && cyc < 400) begin
      cyc++;
      step();
      if (poke && cyc == 1) begin
        i_start   = 1'b1;
        i_tri_cnt = IW'(5);
      end
    end
    check_eq("done_seen", done_seen, 1);
    if (cnt == 0) check_eq("done_latency", cyc, 3);
    check_eq("busy_at_done", done_busy, 0);
    check_eq("done_pulse", o_done, 0);
    check_eq("req_left", exp_q.size(), 0);
    check_eq("res_count", n_res, n_acc);
    check_final();
  endtask

  // Credit instance: withheld results cap accepts at 2, then random
  // ready/result timing must keep the payload stable and finish the batch.
  task automatic credit_test();
    int c_acc, c_ret, cyc;
    bit prev_hold, cdone;
    logic [PW-1:0] prev_pl, e, p;
    c_exp_q.delete(); c_pend_q.delete();
    for (int t = 1; t >= 0; t--)
      for (int r = 0; r < NR; r++) c_exp_q.push_back({IW'(t), RW'(r)});
    c_acc = 0; c_ret = 0;
    c_cnt = IW'(2); c_mode = 1'b0; c_start = 1'b1; c_ready = 1'b1; c_res_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (c_valid && c_ready) begin
        e = c_exp_q.pop_front();
        check_eq("crd_pair", {c_tri, c_ray}, e);
        c_pend_q.push_back({c_tri, c_ray});
        c_acc++;
      end
      @(posedge clk);
      #1;
      c_start = 1'b0;
    end
    check_eq("crd_cap_acc", c_acc, 2);
    check_eq("crd_cap_valid", c_valid, 0);
    prev_hold = 1'b0; cdone = 1'b0; cyc = 0; prev_pl = '0;
    while (!cdone && cyc < 500) begin
      cyc++;
      @(negedge clk);
      if (prev_hold) begin
        check_eq("crd_hold_valid", c_valid, 1);
        check_eq("crd_hold_pl", {c_tri, c_ray}, prev_pl);
      end
      if (c_done) cdone = 1'b1;
      if (c_valid && c_ready) begin
        if (c_exp_q.size() == 0) check_eq("crd_extra", {c_tri, c_ray}, '1);
        else begin
          e = c_exp_q.pop_front();
          check_eq("crd_pair", {c_tri, c_ray}, e);
        end
        c_pend_q.push_back({c_tri, c_ray});
        c_acc++;
      end
      prev_hold = c_valid && !c_ready;
      prev_pl   = {c_tri, c_ray};
      @(posedge clk);
      #1;
      c_ready = 1'($urandom_range(0, 1));
      if (c_pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        p = c_pend_q.pop_front();
        c_res_valid = 1'b1;
        c_res_tri   = p[PW-1:RW];
        c_res_ray   = p[RW-1:0];
        c_res_hit   = 1'b0;
        c_res_t     = '0;
        c_ret++;
      end else begin
        c_res_valid = 1'b0;
      end
    end
    c_res_valid = 1'b0;
    check_eq("crd_done", cdone, 1);
    check_eq("crd_total", c_acc, 8);
    check_eq("crd_returned", c_ret, c_acc);
    check_eq("crd_left", c_exp_q.size(), 0);
  endtask

  task automatic set_basic_tab();
    clear_tab();
    for (int r = 0; r < NR; r++) begin
      hit_tab[1][r] = 1'b1; t_tab[1][r] = 32'h0002_0000;
      hit_tab[2][r] = 1'b1; t_tab[2][r] = 32'h0001_0000;
      hit_tab[0][r] = 1'b0; t_tab[0][r] = 32'h0000_0100;
    end
  endtask

  initial begin
    int guard;
    rstn = 1'b0;
    i_start = 0; i_tri_cnt = '0; i_mode = 0; i_req_ready = 1; i_res_valid = 0;
    i_res_ray = '0; i_res_tri = '0; i_res_hit = 0; i_res_t = '0;
    c_start = 0; c_cnt = '0; c_mode = 0; c_ready = 0; c_res_valid = 0;
    c_res_ray = '0; c_res_tri = '0; c_res_hit = 0; c_res_t = '0;
    hold_res = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_valid", o_req_valid, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_hit", o_hit, 0);
    check_eq("rst_t", o_t[63:0], 0);
    check_eq("rst_idx", o_tri_idx[63:0], 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // closest-hit sweep
    set_basic_tab();
    run_batch(3, 1'b0, 1'b0);

    // ties keep first arrival; negative t wins
    clear_tab();
    hit_tab[2][0] = 1; t_tab[2][0] = 32'h0000_8000;
    hit_tab[0][0] = 1; t_tab[0][0] = 32'h0000_8000;
    hit_tab[2][1] = 1; t_tab[2][1] = 32'h0000_5000;
    hit_tab[1][1] = 1; t_tab[1][1] = 32'hFFFF_FFFF;
    run_batch(3, 1'b0, 1'b0);

    // any-hit skipping
    clear_tab();
    hit_tab[3][1] = 1; t_tab[3][1] = 32'h0003_0000;
    hit_tab[0][1] = 1; t_tab[0][1] = 32'h0000_0001;
    run_batch(4, 1'b1, 1'b0);

    // credit limit and backpressure
    credit_test();

    // empty batch with a start pulse while busy, then a result in IDLE
    set_basic_tab();
    run_batch(0, 1'b0, 1'b1);
    i_res_valid = 1; i_res_ray = '0; i_res_tri = IW'(7); i_res_hit = 1; i_res_t = 32'h10;
    @(posedge clk);
    #1;
    i_res_valid = 0;
    check_eq("idle_res_hit", o_hit, 0);
    check_eq("idle_res_t", o_t[W-1:0], 32'h7FFF_FFFF);

    // reset during DRAIN with results outstanding
    set_basic_tab();
    pend_q.delete();
    build_expected(2, 1'b0);
    hold_res = 1'b1;
    start_batch(2, 1'b0);
    guard = 0;
    do begin
      step();
      guard++;
    end while (!(o_busy && !o_req_valid && exp_q.size() == 0) && guard < 100);
    check_eq("rst_reach_drain", o_busy && !o_req_valid, 1);
    hold_res = 1'b0;
    repeat (3) step();
    hold_res = 1'b1;
    step();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_busy", o_busy, 0);
    check_eq("mid_rst_valid", o_req_valid, 0);
    check_eq("mid_rst_done", o_done, 0);
    check_eq("mid_rst_hit", o_hit, 0);
    check_eq("mid_rst_t", o_t, 0);
    check_eq("mid_rst_idx", o_tri_idx[63:0], 0);
    rstn = 1'b1;
    hold_res = 1'b0;
    repeat (3) step();
    check_eq("late_res_hit", o_hit, 0);
    check_eq("late_res_t", o_t, 0);
    check_eq("late_res_busy", o_busy, 0);
    i_res_valid = 1'b0;
    @(posedge clk);
    #1;

    // fresh batch after reset
    set_basic_tab();
    run_batch(3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
